// File: rtl/bcd_serial_accum.sv
// bcd_serial_accum: multi-digit BCD accumulator (acc <= acc + in_data, decimal).
// A single BCD digit adder is reused over all digits, least significant first,
// rippling the decimal carry through a register between cycles.
module bcd_serial_accum #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic [4*DIGITS-1:0]   acc,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_work;
  logic [W-1:0]     r_opnd;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_overflow;
  logic             r_done;
  logic             r_err;
  logic             r_busy;
  logic             r_in_ready;

  logic [4:0]       w_dsum;
  logic [W+3:0]     w_shift;
  logic [W-1:0]     w_next_work;
  logic             w_last;

  // True when every 4-bit digit of the operand is a legal decimal digit
  function automatic logic all_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // One decimal digit add; returns {carry_out, digit}
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    logic [4:0] s;
    logic [4:0] s_adj;
    s     = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    s_adj = s - 5'd10;
    if (s > 5'd9) return {1'b1, s_adj[3:0]};
    else          return {1'b0, s[3:0]};
  endfunction

  // The working copy and operand both shift right one digit per cycle, so the
  // current digit is always at the bottom and each result digit enters at the
  // top; after DIGITS shifts the result sits in natural order.
  always_comb begin
    w_dsum      = bcd_digit_add(r_work[3:0], r_opnd[3:0], r_carry);
    w_shift     = {w_dsum[3:0], r_work};
    w_next_work = w_shift[W+3:4];
    w_last      = (r_idx == IDX_W'(DIGITS - 1));
  end

  // Control FSM with registered outputs; acc is loaded on the final digit edge
  // so the new value and the done pulse appear together in the DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b1;
      r_idx      <= '0;
      r_carry    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
          end else if (in_valid) begin
            if (all_bcd(in_data)) begin
              r_opnd     <= in_data;
              r_work     <= r_acc;
              r_idx      <= '0;
              r_carry    <= 1'b0;
              r_state    <= S_ADD;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ADD: begin
          r_work  <= w_next_work;
          r_opnd  <= r_opnd >> 4;
          r_carry <= w_dsum[4];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_acc   <= w_next_work;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            if (w_dsum[4]) r_overflow <= 1'b1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign acc      = r_acc;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign err      = r_err;
  assign in_ready = r_in_ready;

endmodule

// File: tb/tb_bcd_serial_accum.sv
// Testbench for bcd_serial_accum (DIGITS=4): directed operands with a
// scoreboard queue of expected done/err events checked by a separate monitor.
module tb_bcd_serial_accum;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] acc;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit           is_err;
    logic [W-1:0] acc;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];

  bcd_serial_accum #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .acc      (acc),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Issue one valid operand and record the expected accumulator afterwards
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] exp_acc, input logic exp_ovf);
    exp_t e;
    wait_ready();
    e.is_err = 1'b0;
    e.acc    = exp_acc;
    e.ovf    = exp_ovf;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    tick();
    wait_ready();
  endtask

  task automatic do_clear();
    wait_ready();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Monitor: every done or err pulse must match the oldest expected event
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, done, err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
          chk("event_acc", {16'd0, acc}, {16'd0, e.acc});
          chk("event_ovf", {31'd0, overflow}, {31'd0, e.ovf});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    // Reset state
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_acc", {16'd0, acc}, 32'h0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // Latency of one add: busy for 4 cycles, done with new acc in the 5th
    e.is_err = 1'b0; e.acc = 16'h1234; e.ovf = 1'b0;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lat_busy", {31'd0, busy}, 32'd1);
      chk("lat_nodone", {31'd0, done}, 32'd0);
      chk("lat_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk("lat_done", {31'd0, done}, 32'd1);
    chk("lat_busy_off", {31'd0, busy}, 32'd0);
    chk("lat_acc", {16'd0, acc}, 32'h1234);
    chk("lat_ready_done", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lat_ready_back", {31'd0, in_ready}, 32'd1);

    // Carry rippling through three digits
    do_clear();
    chk("clear_acc", {16'd0, acc}, 32'h0);
    send(16'h0999, 16'h0999, 1'b0);
    send(16'h0001, 16'h1000, 1'b0);

    // Wrap-around and sticky overflow
    do_clear();
    send(16'h9999, 16'h9999, 1'b0);
    send(16'h0002, 16'h0001, 1'b1);
    send(16'h0001, 16'h0002, 1'b1);
    do_clear();
    chk("clr_acc", {16'd0, acc}, 32'h0);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);

    // Non-BCD operand is rejected with a single err pulse
    send(16'h0042, 16'h0042, 1'b0);
    e.is_err = 1'b1; e.acc = 16'h0042; e.ovf = 1'b0;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_data  = 16'h12A4;
    tick();
    in_valid = 1'b0;
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_ready", {31'd0, in_ready}, 32'd1);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("bad_err_off", {31'd0, err}, 32'd0);
    chk("bad_acc", {16'd0, acc}, 32'h0042);

    // clear / in_valid ignored during ADD
    do_clear();
    send(16'h5555, 16'h5555, 1'b0);
    e.is_err = 1'b0; e.acc = 16'h1110; e.ovf = 1'b1;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    tick();
    in_data  = 16'h1111;
    clear    = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    wait_ready();
    chk("ign_acc", {16'd0, acc}, 32'h1110);
    chk("ign_ovf", {31'd0, overflow}, 32'd1);

    // Reset mid-ADD discards the partial sum and produces no done pulse
    send(16'h4445, 16'h5555, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_acc", {16'd0, acc}, 32'h0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("mid_rst_acc_hold", {16'd0, acc}, 32'h0);

    // All expected events consumed
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
